// File: rtl/mem_controller.sv
// -----------------------------------------------------------------------------
// mem_controller
//
// Single-channel memory arbiter placed directly downstream of the per-thread
// LSUs. Read and write requests from NUM_CONSUMERS LSUs are serialised onto one
// external memory channel, with exactly one transaction outstanding at a time.
// Read data and completion acknowledgements are relayed back to the requesting
// LSU using a four-phase handshake: the LSU drops valid after it sees ready.
//
// Optional feature macro: MEMCTRL_RR_EN
//   defined   : round-robin arbitration. The search starts at the index after
//               the last grant. After reset, consumer 0 has top priority.
//   undefined : fixed priority, lowest index wins, no pointer register.
//
// Ports:
//   clk                    in   clock, all logic on the rising edge
//   reset                  in   synchronous, active-high reset
//   consumer_read_valid    in   [N]      per-LSU read request
//   consumer_read_address  in   [N*A]    per-LSU read address (slice i)
//   consumer_read_ready    out  [N]      per-LSU read done / data valid
//   consumer_read_data     out  [N*D]    per-LSU returned read data
//   consumer_write_valid   in   [N]      per-LSU write request
//   consumer_write_address in   [N*A]    per-LSU write address
//   consumer_write_data    in   [N*D]    per-LSU write data
//   consumer_write_ready   out  [N]      per-LSU write done
//   mem_read_valid         out          read request to memory
//   mem_read_address       out  [A]     read address to memory
//   mem_read_ready         in           memory read complete, data valid
//   mem_read_data          in   [D]     read data from memory
//   mem_write_valid        out          write request to memory
//   mem_write_address      out  [A]     write address to memory
//   mem_write_data         out  [D]     write data to memory
//   mem_write_ready        in           memory write complete
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAITING,
    S_WRITE_WAITING,
    S_READ_RELAYING,
    S_WRITE_RELAYING
  } state_t;

  // Per-consumer views of the flattened request buses.
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] w_rd_addr;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] w_wr_addr;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] w_wr_data;
  logic [NUM_CONSUMERS-1:0]                w_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_unpack
      assign w_rd_addr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign w_wr_addr[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
      assign w_wr_data[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
      assign w_req[gi]     = consumer_read_valid[gi] | consumer_write_valid[gi];
    end
  endgenerate

  // State and registered outputs
  state_t                                  r_state;
  logic [IDX_W-1:0]                        r_grant;
  logic                                    r_mem_read_valid;
  logic [ADDR_BITS-1:0]                    r_mem_read_address;
  logic                                    r_mem_write_valid;
  logic [ADDR_BITS-1:0]                    r_mem_write_address;
  logic [DATA_BITS-1:0]                    r_mem_write_data;
  logic [NUM_CONSUMERS-1:0]                r_cons_read_ready;
  logic [NUM_CONSUMERS-1:0]                r_cons_write_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_cons_read_data;

  // Next-state values
  state_t                                  w_state_next;
  logic [IDX_W-1:0]                        w_grant_next;
  logic                                    w_mem_read_valid_next;
  logic [ADDR_BITS-1:0]                    w_mem_read_address_next;
  logic                                    w_mem_write_valid_next;
  logic [ADDR_BITS-1:0]                    w_mem_write_address_next;
  logic [DATA_BITS-1:0]                    w_mem_write_data_next;
  logic [NUM_CONSUMERS-1:0]                w_cons_read_ready_next;
  logic [NUM_CONSUMERS-1:0]                w_cons_write_ready_next;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] w_cons_read_data_next;

  // Arbitration result
  logic             w_found;
  logic [IDX_W-1:0] w_sel;

`ifdef MEMCTRL_RR_EN
  // Holds the last granted index; reset to the top index so the first search
  // begins at consumer 0.
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_ptr_next;
  int               w_rr_idx;

  always_comb begin
    w_found  = 1'b0;
    w_sel    = '0;
    w_rr_idx = 0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      w_rr_idx = (int'(r_rr_ptr) + 1 + k) % NUM_CONSUMERS;
      if (!w_found && w_req[w_rr_idx]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(w_rr_idx);
      end
    end
  end

  assign w_rr_ptr_next = (r_state == S_IDLE && w_found) ? w_sel : r_rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) r_rr_ptr <= IDX_W'(NUM_CONSUMERS - 1);
    else       r_rr_ptr <= w_rr_ptr_next;
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (!w_found && w_req[k]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(k);
      end
    end
  end
`endif

  // Next-state and output logic
  always_comb begin
    w_state_next             = r_state;
    w_grant_next             = r_grant;
    w_mem_read_valid_next    = r_mem_read_valid;
    w_mem_read_address_next  = r_mem_read_address;
    w_mem_write_valid_next   = r_mem_write_valid;
    w_mem_write_address_next = r_mem_write_address;
    w_mem_write_data_next    = r_mem_write_data;
    w_cons_read_ready_next   = r_cons_read_ready;
    w_cons_write_ready_next  = r_cons_write_ready;
    w_cons_read_data_next    = r_cons_read_data;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_next = w_sel;
          // A read beats a write from the same consumer.
          if (consumer_read_valid[w_sel]) begin
            w_mem_read_valid_next   = 1'b1;
            w_mem_read_address_next = w_rd_addr[w_sel];
            w_state_next            = S_READ_WAITING;
          end else begin
            w_mem_write_valid_next   = 1'b1;
            w_mem_write_address_next = w_wr_addr[w_sel];
            w_mem_write_data_next    = w_wr_data[w_sel];
            w_state_next             = S_WRITE_WAITING;
          end
        end
      end

      S_READ_WAITING: begin
        if (mem_read_ready) begin
          w_mem_read_valid_next           = 1'b0;
          w_cons_read_ready_next[r_grant] = 1'b1;
          w_cons_read_data_next[r_grant]  = mem_read_data;
          w_state_next                    = S_READ_RELAYING;
        end
      end

      S_WRITE_WAITING: begin
        if (mem_write_ready) begin
          w_mem_write_valid_next           = 1'b0;
          w_cons_write_ready_next[r_grant] = 1'b1;
          w_state_next                     = S_WRITE_RELAYING;
        end
      end

      S_READ_RELAYING: begin
        if (!consumer_read_valid[r_grant]) begin
          w_cons_read_ready_next[r_grant] = 1'b0;
          w_state_next                    = S_IDLE;
        end
      end

      S_WRITE_RELAYING: begin
        if (!consumer_write_valid[r_grant]) begin
          w_cons_write_ready_next[r_grant] = 1'b0;
          w_state_next                     = S_IDLE;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= S_IDLE;
      r_grant             <= '0;
      r_mem_read_valid    <= 1'b0;
      r_mem_read_address  <= '0;
      r_mem_write_valid   <= 1'b0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
      r_cons_read_ready   <= '0;
      r_cons_write_ready  <= '0;
      r_cons_read_data    <= '0;
    end else begin
      r_state             <= w_state_next;
      r_grant             <= w_grant_next;
      r_mem_read_valid    <= w_mem_read_valid_next;
      r_mem_read_address  <= w_mem_read_address_next;
      r_mem_write_valid   <= w_mem_write_valid_next;
      r_mem_write_address <= w_mem_write_address_next;
      r_mem_write_data    <= w_mem_write_data_next;
      r_cons_read_ready   <= w_cons_read_ready_next;
      r_cons_write_ready  <= w_cons_write_ready_next;
      r_cons_read_data    <= w_cons_read_data_next;
    end
  end

  assign mem_read_valid       = r_mem_read_valid;
  assign mem_read_address     = r_mem_read_address;
  assign mem_write_valid      = r_mem_write_valid;
  assign mem_write_address    = r_mem_write_address;
  assign mem_write_data       = r_mem_write_data;
  assign consumer_read_ready  = r_cons_read_ready;
  assign consumer_write_ready = r_cons_write_ready;
  assign consumer_read_data   = r_cons_read_data;

endmodule
